video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing and test-pattern generator; drives the TMDS encoder (hSync/vSync/DrawArea/RGB).
//  Generalises the fixed-mode generator: programmable timing, sync polarity, colour depth, pixel clock-enable.
//  Adds five runtime-selectable patterns, switched only on frame boundaries, plus a frame-start strobe.
// PARAMETERS
//  H_ACTIVE 800 visible pixels/line;  H_FP 40;  H_SYNC 48;  H_BP 40  (H_TOTAL = sum)
//  V_ACTIVE 480 visible lines/frame;  V_FP 13;  V_SYNC 3;   V_BP 29  (V_TOTAL = sum)
//  HSYNC_POL 1'b0  asserted level of hSync;  VSYNC_POL 1'b0  asserted level of vSync
//  COLOR_W 8   bits per colour channel
//  CHECK_LOG2 5  checkerboard square = 2^CHECK_LOG2 pixels
//  MOVE_STEP 4   moving-bar advance, pixels per frame;  BAR_W 16  moving-bar width, pixels
// PORTS
//  pixclk       in   1        pixel-domain clock
//  reset        in   1        synchronous, active-high reset
//  ce           in   1        pixel clock-enable; all registers advance only when 1
//  pattern_sel  in   3        0 black, 1 colour bars, 2 checkerboard, 3 gradient, 4 moving bar, 5-7 black
//  hSync        out  1        horizontal sync, HSYNC_POL when asserted
//  vSync        out  1        vertical sync, VSYNC_POL when asserted
//  DrawArea     out  1        1 when the pixel is in the visible area
//  red/green/blue out COLOR_W each  pixel colour; 0 outside DrawArea
//  frame_start  out  1        1 for the pixel (x=0,y=0)
//  x            out  clog2(H_TOTAL)  horizontal position of current output pixel
//  y            out  clog2(V_TOTAL)  vertical position of current output pixel
// BEHAVIOUR
//  Reset (sync): hcnt=vcnt=0, active pattern=0, bar offset=0, frame count=0;
//   outputs DrawArea=0, hSync=~HSYNC_POL, vSync=~VSYNC_POL, RGB=0, frame_start=0, x=y=0.
//  Counters: on ce, hcnt increments and wraps H_TOTAL-1 -> 0; vcnt increments on that wrap, wraps V_TOTAL-1 -> 0.
//  All outputs registered: 1 ce-cycle latency from counter state; sync, DrawArea, RGB, x, y mutually aligned.
//  DrawArea = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
//  hSync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  vSync asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); changes with hcnt=0 of the line.
//  ce=0: every register, outputs included, holds; frame_start is a level; consumers qualify it with ce.
//  Pattern latch: pattern_sel sampled on ce when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
//   A whole frame always uses one pattern; mid-frame changes are ignored until that point.
//  Bar offset: advances by MOVE_STEP modulo H_ACTIVE at the same frame-end point, in every pattern mode.
//  Patterns (inside DrawArea; full scale = all ones):
//   1 bars: 8 bars of width H_ACTIVE/8 (integer division), left to right:
//     white, yellow, cyan, green, magenta, red, blue, black.
//     Remainder pixels beyond 8*(H_ACTIVE/8) are black.
//     Use a bar-width counter; no multiplier.
//   2 checker: white if x[CHECK_LOG2]^y[CHECK_LOG2], else black.
//   3 gradient: R=G=B=x[COLOR_W-1:0]; wraps every 2^COLOR_W pixels.
//   4 moving bar: white where (x-offset) mod H_ACTIVE < BAR_W, else blue; the bar wraps around the right edge.
//   0,5,6,7: all channels 0.
//  Reset asserted mid-frame: the next cycle restarts at (0,0) with pattern 0 and the reset output values above.
//  Reset overrides ce.
// TESTING (small params: H 16/2/3/3 -> H_TOTAL 24; V 8/1/2/1 -> V_TOTAL 12; COLOR_W 4; CHECK_LOG2 1; MOVE_STEP 4; BAR_W 4)
//  Reset then ce=1, 2 frames -> frame_start every 288 cycles; 128 DrawArea cycles/frame;
//   hSync low (POL=0) at x=18..20; vSync low on lines 9..10 only.
//  pattern_sel=1 from reset -> frame 0 black; in frame 1, line 0: x=0,1 white(F,F,F), x=2,3 yellow(F,F,0),
//   ..., x=14,15 black; blanking RGB=0.
//  Change pattern_sel 1->2 at y=3 -> rest of frame stays bars; next frame checker:
//   (0,0) black, (2,0) white, (2,2) black.
//  pattern_sel=4 -> in frames n=1,2,3,4 white at x=[4n mod 16 .. +3];
//   in frame 4, x=0..3 white (offset wrapped to 0).
//  ce toggled 1,0,0,1 -> outputs/counters frozen during ce=0; the sequence matches the ce=1 run with gaps removed.
//  Assert reset at (x=7,y=5) for 1 cycle -> next output x=0,y=0, DrawArea 0, RGB 0; pattern back to 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern generator: programmable porch/sync timing, five
// frame-synchronous test patterns, all outputs registered one ce-cycle behind the counters.
module video_timing_gen #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 40,
  parameter int   H_SYNC     = 48,
  parameter int   H_BP       = 40,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 13,
  parameter int   V_SYNC     = 3,
  parameter int   V_BP       = 29,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   COLOR_W    = 8,
  parameter int   CHECK_LOG2 = 5,
  parameter int   MOVE_STEP  = 4,
  parameter int   BAR_W      = 16,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = $clog2(H_TOTAL),
  localparam int  VW         = $clog2(V_TOTAL)
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic               ce,
  input  logic [2:0]         pattern_sel,
  output logic               hSync,
  output logic               vSync,
  output logic               DrawArea,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               frame_start,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y
);

  localparam int OW     = $clog2(H_ACTIVE);
  localparam int BAR_PX = H_ACTIVE / 8;
  localparam int BPW    = $clog2(BAR_PX + 1);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int VS_BEG = V_ACTIVE + V_FP;

  typedef enum logic [2:0] {
    PAT_BLACK = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_CHECK = 3'd2,
    PAT_GRAD  = 3'd3,
    PAT_MOVE  = 3'd4
  } pattern_e;

  // Raster and frame state
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  pattern_e       pat_q, pat_d;
  logic [OW-1:0]  off_q, off_d;
  logic [BPW-1:0] bar_px_q, bar_px_d;
  logic [3:0]     bar_idx_q, bar_idx_d;

  // Registered outputs
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               fs_q, fs_d;
  logic [HW-1:0]      x_q, x_d;
  logic [VW-1:0]      y_q, y_d;

  logic h_last, v_last;
  logic draw, hs_on, vs_on;
  int   hpos, vpos, bar_diff;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    h_last    = (int'(hcnt_q) == H_TOTAL - 1);
    v_last    = (int'(vcnt_q) == V_TOTAL - 1);
    hcnt_d    = h_last ? '0 : hcnt_q + HW'(1);
    vcnt_d    = vcnt_q;
    pat_d     = pat_q;
    off_d     = off_q;
    bar_px_d  = bar_px_q + BPW'(1);
    bar_idx_d = bar_idx_q;

    if (h_last) begin
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
    end

    // Pattern and bar offset only change between frames, so a frame is never mixed.
    if (h_last && v_last) begin
      pat_d = (pattern_sel <= 3'd4) ? pattern_e'(pattern_sel) : PAT_BLACK;
      off_d = (int'(off_q) >= H_ACTIVE - MOVE_STEP) ? off_q - OW'(H_ACTIVE - MOVE_STEP)
                                                    : off_q + OW'(MOVE_STEP);
    end

    // Bar index tracks hcnt by counting bar widths, saturating at 8 (black remainder).
    if (h_last) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (int'(bar_px_q) == BAR_PX - 1) begin
      bar_px_d = '0;
      if (bar_idx_q != 4'd8) begin
        bar_idx_d = bar_idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    hpos     = int'(hcnt_q);
    vpos     = int'(vcnt_q);
    draw     = (hpos < H_ACTIVE) && (vpos < V_ACTIVE);
    hs_on    = (hpos >= HS_BEG) && (hpos < HS_BEG + H_SYNC);
    vs_on    = (vpos >= VS_BEG) && (vpos < VS_BEG + V_SYNC);
    bar_diff = (hpos >= int'(off_q)) ? hpos - int'(off_q) : hpos + H_ACTIVE - int'(off_q);

    hsync_d = hs_on ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = vs_on ? VSYNC_POL : ~VSYNC_POL;
    de_d    = draw;
    fs_d    = (hpos == 0) && (vpos == 0);
    x_d     = hcnt_q;
    y_d     = vcnt_q;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;

    if (draw) begin
      case (pat_q)
        PAT_BARS: begin
          // Index bits map directly onto the white..black bar order.
          if (bar_idx_q < 4'd8) begin
            red_d   = {COLOR_W{~bar_idx_q[1]}};
            green_d = {COLOR_W{~bar_idx_q[2]}};
            blue_d  = {COLOR_W{~bar_idx_q[0]}};
          end
        end
        PAT_CHECK: begin
          if (hpos[CHECK_LOG2] ^ vpos[CHECK_LOG2]) begin
            red_d   = '1;
            green_d = '1;
            blue_d  = '1;
          end
        end
        PAT_GRAD: begin
          red_d   = hpos[COLOR_W-1:0];
          green_d = hpos[COLOR_W-1:0];
          blue_d  = hpos[COLOR_W-1:0];
        end
        PAT_MOVE: begin
          blue_d = '1;
          if (bar_diff < BAR_W) begin
            red_d   = '1;
            green_d = '1;
          end
        end
        default: begin
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge pixclk) begin
    // NOTE: reset is checked before ce so it wins even while the pixel enable is low.
    if (reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pat_q     <= PAT_BLACK;
      off_q     <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      de_q      <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      fs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else if (ce) begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pat_q     <= pat_d;
      off_q     <= off_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      fs_q      <= fs_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign DrawArea    = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = fs_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-arithmetic reference model queues the
// expected pixel for every enabled cycle; a negedge monitor pops and compares.
module tb_video_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int CW = 4, CL = 1, MS = 4, BW = 4;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic [4:0]    x;
    logic [3:0]    y;
  } exp_t;

  logic          pixclk;
  logic          reset;
  logic          ce;
  logic [2:0]    pattern_sel;
  logic          hSync, vSync, DrawArea, frame_start;
  logic [CW-1:0] red, green, blue;
  logic [4:0]    x;
  logic [3:0]    y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .COLOR_W(CW), .CHECK_LOG2(CL), .MOVE_STEP(MS), .BAR_W(BW)
  ) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .ce         (ce),
    .pattern_sel(pattern_sel),
    .hSync      (hSync),
    .vSync      (vSync),
    .DrawArea   (DrawArea),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_start(frame_start),
    .x          (x),
    .y          (y)
  );

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   fs_cnt  = 0;
  int   de_cnt  = 0;
  exp_t sb_q[$];
  int   t       = 0;
  int   fpat    = 0;

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got de=%0b hs=%0b vs=%0b fs=%0b rgb=%h/%h/%h x=%0d y=%0d, expected de=%0b hs=%0b vs=%0b fs=%0b rgb=%h/%h/%h x=%0d y=%0d",
               name, got.de, got.hs, got.vs, got.fs, got.r, got.g, got.b, got.x, got.y,
               exp.de, exp.hs, exp.vs, exp.fs, exp.r, exp.g, exp.b, exp.x, exp.y);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Colour bars in display order, as {R,G,B} on/off.
  function automatic logic [2:0] bar_colour(input int idx);
    case (idx)
      0:       return 3'b111; // white
      1:       return 3'b110; // yellow
      2:       return 3'b011; // cyan
      3:       return 3'b010; // green
      4:       return 3'b101; // magenta
      5:       return 3'b100; // red
      6:       return 3'b001; // blue
      default: return 3'b000; // black
    endcase
  endfunction

  function automatic exp_t pixel(input int px, input int py, input int pat, input int off);
    exp_t       e;
    logic [2:0] c;
    e    = '0;
    c    = 3'b000;
    e.x  = 5'(px);
    e.y  = 4'(py);
    e.fs = (px == 0) && (py == 0);
    e.de = (px < HA) && (py < VA);
    e.hs = !((px >= HA + HFP) && (px < HA + HFP + HS));
    e.vs = !((py >= VA + VFP) && (py < VA + VFP + VS));
    if (e.de) begin
      case (pat)
        1: c = bar_colour(px / (HA / 8));
        2: c = ((((px >> CL) ^ (py >> CL)) & 1) != 0) ? 3'b111 : 3'b000;
        3: begin
          e.r = CW'(px % (1 << CW));
          e.g = CW'(px % (1 << CW));
          e.b = CW'(px % (1 << CW));
        end
        4: c = (((px - off + HA) % HA) < BW) ? 3'b111 : 3'b001;
        default: c = 3'b000;
      endcase
    end
    if (pat != 3) begin
      e.r = {CW{c[2]}};
      e.g = {CW{c[1]}};
      e.b = {CW{c[0]}};
    end
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  // One clock of stimulus; the model works from t = enabled cycles since reset.
  task automatic cyc(input bit c, input bit r);
    ce    = c;
    reset = r;
    if (r) begin
      sb_q.push_back(reset_exp());
      t    = 0;
      fpat = 0;
    end else if (c) begin
      sb_q.push_back(pixel(t % HT, (t / HT) % VT, fpat, ((t / FT) * MS) % HA));
      if (t % FT == FT - 1) fpat = (pattern_sel <= 3'd4) ? int'(pattern_sel) : 0;
      t++;
    end
    @(posedge pixclk);
    #1;
  endtask

  task automatic run(input int n, input bit rand_ce);
    int done;
    done = 0;
    while (done < n) begin
      if (rand_ce && $urandom_range(0, 3) == 0) begin
        cyc(1'b0, 1'b0);
      end else begin
        cyc(1'b1, 1'b0);
        done++;
      end
    end
  endtask

  // Monitor: an output is presented after every edge that saw ce or reset.
  logic out_valid = 1'b0;
  always @(posedge pixclk) out_valid <= ce | reset;

  exp_t last_exp;
  bit   have_last = 1'b0;

  always @(negedge pixclk) begin
    exp_t got;
    exp_t e;
    got.de = DrawArea;
    got.hs = hSync;
    got.vs = vSync;
    got.fs = frame_start;
    got.r  = red;
    got.g  = green;
    got.b  = blue;
    got.x  = x;
    got.y  = y;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got output x=%0d y=%0d, expected none", x, y);
      end else begin
        e = sb_q.pop_front();
        check("pixel", got, e);
        last_exp  = e;
        have_last = 1'b1;
        if (got.fs) fs_cnt++;
        if (got.de) de_cnt++;
      end
    end else if (have_last) begin
      check("hold_when_ce_low", got, last_exp);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "tb_video_timing_gen timeout");
  end

  initial begin
    reset       = 1'b1;
    ce          = 1'b0;
    pattern_sel = 3'd1;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);

    // Two full frames: frame 0 black, frame 1 colour bars.
    fs_cnt = 0;
    de_cnt = 0;
    run(2 * FT, 1'b0);
    @(negedge pixclk);
    #1;
    check_int("frame_start_count", fs_cnt, 2);
    check_int("drawarea_count", de_cnt, 2 * HA * VA);

    // Bars continue after a mid-frame switch; checker from the next frame.
    run(3 * HT, 1'b0);
    pattern_sel = 3'd2;
    run(FT - 3 * HT, 1'b0);
    pattern_sel = 3'd3;
    run(FT, 1'b0);
    pattern_sel = 3'd4;
    run(FT, 1'b0);

    // Moving bar across several frames with ce gaps, including an explicit 1,0,0,1.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    run(5 * FT, 1'b1);

    // Random pattern changes, including the unused codes 5..7.
    for (int i = 0; i < 4 * FT; i++) begin
      if ($urandom_range(0, 49) == 0) pattern_sel = 3'($urandom_range(0, 7));
      run(1, 1'b1);
    end

    // Reset mid-frame at (7,5), then carry on with the moving bar.
    pattern_sel = 3'd4;
    for (int i = 0; i < FT && !((t % HT) == 7 && ((t / HT) % VT) == 5); i++) begin
      cyc(1'b1, 1'b0);
    end
    cyc(1'b1, 1'b1);
    run(FT + 2 * HT, 1'b1);

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge pixclk);
    #1;
    check_int("scoreboard_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
